// File: rtl/ac_motor_pwm.sv
// rtl/ac_motor_pwm.sv - three-phase center-aligned PWM with dead time and fault latch
// Triangle carrier, valley-loaded duty shadows, per-phase dead-time gating.
module ac_motor_pwm #(
  parameter int SINE_WIDTH = 24,
  parameter int PWM_BITS   = 12,
  parameter int DEAD_TIME  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [SINE_WIDTH-1:0] sine1,
  input  logic signed [SINE_WIDTH-1:0] sine2,
  input  logic signed [SINE_WIDTH-1:0] sine3,
  input  logic                         fault,
  input  logic                         fault_clear,
  output logic [2:0]                   pwm_hi,
  output logic [2:0]                   pwm_lo,
  output logic                         period_start,
  output logic                         fault_latched
);

  localparam int DTW = $clog2(DEAD_TIME + 1);
  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] ONE    = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] MID    = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [DTW-1:0]      DT_MAX = DTW'(DEAD_TIME);

  logic [PWM_BITS-1:0]             cnt_q, cnt_d;
  logic                            dir_up_q, dir_up_d;
  logic [2:0][PWM_BITS-1:0]        duty_q, duty_d;
  logic [2:0]                      raw_q, raw_d;
  logic [2:0][DTW-1:0]             dt_q, dt_d;
  logic [2:0]                      pwm_hi_q, pwm_hi_d;
  logic [2:0]                      pwm_lo_q, pwm_lo_d;
  logic                            fault_latched_q, fault_latched_d;
  logic [2:0][PWM_BITS-1:0]        scaled;
  logic                            running;
  logic                            load;
  logic                            unused_sine_lsbs;

  // Top bits of the signed reference plus half-scale equals (sine >>> shift) + 2^(PWM_BITS-1).
  assign scaled[0] = sine1[SINE_WIDTH-1 -: PWM_BITS] + MID;
  assign scaled[1] = sine2[SINE_WIDTH-1 -: PWM_BITS] + MID;
  assign scaled[2] = sine3[SINE_WIDTH-1 -: PWM_BITS] + MID;
  assign unused_sine_lsbs = ^{sine1[SINE_WIDTH-PWM_BITS-1:0],
                              sine2[SINE_WIDTH-PWM_BITS-1:0],
                              sine3[SINE_WIDTH-PWM_BITS-1:0]};

  assign running = enable & ~fault_latched_q;
  assign load    = running & dir_up_q & (cnt_q == '0);

  always_comb begin
    cnt_d           = cnt_q;
    dir_up_d        = dir_up_q;
    duty_d          = duty_q;
    raw_d           = raw_q;
    dt_d            = dt_q;
    pwm_hi_d        = '0;
    pwm_lo_d        = '0;
    fault_latched_d = fault_latched_q;

    if (fault)
      fault_latched_d = 1'b1;
    else if (fault_clear)
      fault_latched_d = 1'b0;

    if (!running) begin
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else if (dir_up_q) begin
      if (cnt_q == MAX) begin
        cnt_d    = MAX_M1;
        dir_up_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == ONE) begin
        cnt_d    = '0;
        dir_up_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    for (int i = 0; i < 3; i++) begin
      if (load)
        duty_d[i] = scaled[i];
      raw_d[i] = running & (duty_q[i] > cnt_q);
      if (!running || (raw_d[i] != raw_q[i]))
        dt_d[i] = '0;
      else if (dt_q[i] != DT_MAX)
        dt_d[i] = dt_q[i] + 1'b1;
      // A fault seen this cycle kills the gates on the same edge it is latched.
      if (running && !fault && (dt_q[i] == DT_MAX)) begin
        pwm_hi_d[i] = raw_q[i];
        pwm_lo_d[i] = ~raw_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q           <= '0;
      dir_up_q        <= 1'b1;
      duty_q          <= {3{MID}};
      raw_q           <= '0;
      dt_q            <= '0;
      pwm_hi_q        <= '0;
      pwm_lo_q        <= '0;
      fault_latched_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      dir_up_q        <= dir_up_d;
      duty_q          <= duty_d;
      raw_q           <= raw_d;
      dt_q            <= dt_d;
      pwm_hi_q        <= pwm_hi_d;
      pwm_lo_q        <= pwm_lo_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign pwm_hi        = pwm_hi_q;
  assign pwm_lo        = pwm_lo_q;
  assign period_start  = load;
  assign fault_latched = fault_latched_q;

endmodule
